// File: rtl/rocfifo_ew_arbiter.sv
// Merges one event from each SIM_ROC_FIFO into EW_FIFO: a summed header word
// followed by every FIFO's payload in index order (serdesclk domain).
module rocfifo_ew_arbiter #(
   parameter int NROCFIFO  = 4,
   parameter int DIGI_BITS = 32,
   parameter int TAG_BITS  = 20
) (
   input  logic                          serdesclk,
   input  logic                          serdesclk_resetn,
   input  logic                          enable,
   input  logic [NROCFIFO-1:0]           rocfifo_empty,
   input  logic [NROCFIFO*DIGI_BITS-1:0] rocfifo_data,
   output logic [NROCFIFO-1:0]           rocfifo_re,
   input  logic                          ew_full,
   output logic                          ew_we,
   output logic [DIGI_BITS-1:0]          ew_data,
   output logic                          evt_done,
   output logic [19:0]                   evt_cnt,
   output logic                          tag_mismatch,
   output logic                          size_overflow
);

   localparam int IDX_W = 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NROCFIFO - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HREQ  = 3'd1;
   localparam logic [2:0] S_HLAT  = 3'd2;
   localparam logic [2:0] S_HCAP  = 3'd3;
   localparam logic [2:0] S_EWHDR = 3'd4;
   localparam logic [2:0] S_PAY   = 3'd5;
   localparam logic [2:0] S_DRAIN = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   logic [2:0]          state;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_inc;
   logic [11:0]         rem;
   logic [11:0]         size_q [NROCFIFO];
   logic [TAG_BITS-1:0] tag_q  [NROCFIFO];

   logic                rd_vld_p0;
   logic [IDX_W-1:0]    rd_sel_p0;

   logic [DIGI_BITS-1:0] cap_word;
   logic [DIGI_BITS-1:0] pay_word;
   logic [DIGI_BITS-1:0] hdr_word;
   logic                 empty_sel;
   logic                 rd_hdr;
   logic                 pay_rd;
   logic                 hdr_wr;
   logic [12:0]          sum_acc;
   logic                 tag_diff;

   // Saturates at 4096 so the 13-bit accumulator never wraps; bit 12 flags overflow.
   function automatic logic [12:0] sat_add13(input logic [12:0] acc, input logic [11:0] val);
      logic [13:0] s;
      s = {1'b0, acc} + {2'b00, val};
      if (s > 14'd4096) return 13'd4096;
      return s[12:0];
   endfunction

   function automatic logic [11:0] sat12(input logic [12:0] acc);
      return acc[12] ? 12'hFFF : acc[11:0];
   endfunction

   assign idx_inc = idx + 1'b1;

   always_comb begin
      cap_word  = '0;
      pay_word  = '0;
      empty_sel = 1'b1;
      for (int i = 0; i < NROCFIFO; i++) begin
         if (idx == IDX_W'(i)) begin
            cap_word  = rocfifo_data[i*DIGI_BITS +: DIGI_BITS];
            empty_sel = rocfifo_empty[i];
         end
         if (rd_sel_p0 == IDX_W'(i)) pay_word = rocfifo_data[i*DIGI_BITS +: DIGI_BITS];
      end
   end

   always_comb begin
      sum_acc  = '0;
      tag_diff = 1'b0;
      for (int i = 0; i < NROCFIFO; i++) begin
         sum_acc = sat_add13(sum_acc, size_q[i]);
         if (tag_q[i] != tag_q[0]) tag_diff = 1'b1;
      end
      hdr_word                 = '0;
      hdr_word[31:20]          = sat12(sum_acc);
      hdr_word[TAG_BITS-1:0]   = tag_q[0];
   end

   // Read enables are combinational so empty/ew_full gate the same cycle.
   always_comb begin
      rd_hdr = (state == S_HREQ) && !empty_sel;
      pay_rd = (state == S_PAY) && (rem != 12'd0) && !empty_sel && !ew_full;
      hdr_wr = (state == S_EWHDR) && !ew_full;
      rocfifo_re = '0;
      for (int i = 0; i < NROCFIFO; i++) begin
         if (idx == IDX_W'(i)) rocfifo_re[i] = rd_hdr | pay_rd;
      end
   end

   always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
      if (!serdesclk_resetn) begin
         state         <= S_IDLE;
         idx           <= '0;
         rem           <= '0;
         evt_done      <= 1'b0;
         evt_cnt       <= '0;
         tag_mismatch  <= 1'b0;
         size_overflow <= 1'b0;
         for (int i = 0; i < NROCFIFO; i++) begin
            size_q[i] <= '0;
            tag_q[i]  <= '0;
         end
      end else begin
         evt_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  idx   <= '0;
                  state <= S_HREQ;
               end
            end
            S_HREQ: begin
               if (rd_hdr) state <= S_HLAT;
            end
            S_HLAT: state <= S_HCAP;
            S_HCAP: begin
               size_q[idx] <= cap_word[31:20];
               tag_q[idx]  <= cap_word[TAG_BITS-1:0];
               if (idx != LAST_IDX) begin
                  idx   <= idx_inc;
                  state <= S_HREQ;
               end else begin
                  state <= S_EWHDR;
               end
            end
            S_EWHDR: begin
               if (hdr_wr) begin
                  tag_mismatch  <= tag_mismatch | tag_diff;
                  size_overflow <= size_overflow | sum_acc[12];
                  idx           <= '0;
                  rem           <= size_q[0];
                  state         <= S_PAY;
               end
            end
            S_PAY: begin
               if (rem == 12'd0) begin
                  if (idx != LAST_IDX) begin
                     idx <= idx_inc;
                     rem <= size_q[idx_inc];
                  end else begin
                     state <= S_DRAIN;
                  end
               end else if (pay_rd) begin
                  rem <= rem - 12'd1;
               end
            end
            S_DRAIN: state <= S_DONE;
            S_DONE: begin
               evt_done <= 1'b1;
               evt_cnt  <= evt_cnt + 20'd1;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // p0: payload read issued; p1: data returned by the FIFO is written out
   always_ff @(posedge serdesclk or negedge serdesclk_resetn) begin
      if (!serdesclk_resetn) begin
         rd_vld_p0 <= 1'b0;
         rd_sel_p0 <= '0;
         ew_we     <= 1'b0;
         ew_data   <= '0;
      end else begin
         rd_vld_p0 <= pay_rd;
         rd_sel_p0 <= idx;
         if (hdr_wr) begin
            ew_we   <= 1'b1;
            ew_data <= hdr_word;
         end else begin
            ew_we <= rd_vld_p0;
            if (rd_vld_p0) ew_data <= pay_word;
         end
      end
   end

endmodule
